// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift-and-correct step per clock.
// Optional build macro BIN_TO_BCD_SIGNED_EN treats bin as two's complement and reports the sign on neg.
module bin_to_bcd_seq #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic [3:0]   bcd7,
    output logic [3:0]   bcd6,
    output logic [3:0]   bcd5,
    output logic [3:0]   bcd4,
    output logic [3:0]   bcd3,
    output logic [3:0]   bcd2,
    output logic [3:0]   bcd1,
    output logic [3:0]   bcd0,
    output logic         ovf,
    output logic         neg
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    state_t        state_q;
    logic [W-1:0]  sh_q;
    logic [31:0]   sc_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_acc_q;
    logic          neg_acc_q;
    logic [31:0]   bcd_q;
    logic          ovf_q;
    logic          neg_q;
    logic          busy_q;
    logic          done_q;

    logic [31:0]   sc_adj;
    logic [W+31:0] word_shl;
    logic [31:0]   sc_d;
    logic [W-1:0]  sh_d;
    logic [W-1:0]  mag_d;
    logic          load_neg_d;

    // Each nibble is corrected independently; a 4-bit add never carries into its neighbour.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nib
            assign sc_adj[4*gi +: 4] = (sc_q[4*gi +: 4] >= 4'd5) ? (sc_q[4*gi +: 4] + 4'd3)
                                                                : sc_q[4*gi +: 4];
        end
    endgenerate

    assign word_shl = {sc_adj, sh_q} << 1;
    assign sc_d     = word_shl[W+31:W];
    assign sh_d     = word_shl[W-1:0];

`ifdef BIN_TO_BCD_SIGNED_EN
    // W-bit negation: the most negative value maps onto its own bit pattern, read as 2^(W-1).
    assign mag_d      = bin[W-1] ? (~bin + W'(1)) : bin;
    assign load_neg_d = bin[W-1];
`else
    assign mag_d      = bin;
    assign load_neg_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            sc_q      <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            neg_acc_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sh_q      <= mag_d;
                        sc_q      <= '0;
                        ovf_acc_q <= 1'b0;
                        neg_acc_q <= load_neg_d;
                        cnt_q     <= CW'(W);
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    sc_q  <= sc_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - CW'(1);
                    // Any bit leaving the top digit means the value reached 10^8.
                    if (sc_adj[31]) begin
                        ovf_acc_q <= 1'b1;
                    end
                    if (cnt_q == CW'(1)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    bcd_q   <= sc_q;
                    ovf_q   <= ovf_acc_q;
                    neg_q   <= neg_acc_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd7 = bcd_q[31:28];
    assign bcd6 = bcd_q[27:24];
    assign bcd5 = bcd_q[23:20];
    assign bcd4 = bcd_q[19:16];
    assign bcd3 = bcd_q[15:12];
    assign bcd2 = bcd_q[11:8];
    assign bcd1 = bcd_q[7:4];
    assign bcd0 = bcd_q[3:0];
    assign ovf  = ovf_q;
    assign neg  = neg_q;

endmodule
